// File: rtl/axi_slv_mem_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | axi_if : AXI3-style bus bundle (AW/W/B/AR/R) with slave modport  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

interface axi_if #(
    parameter int ID_WIDTH   = `D_ID_WIDTH,
    parameter int ADDR_WIDTH = `D_ADDR_WIDTH,
    parameter int DATA_WIDTH = `D_DATA_WIDTH
) ();
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ID_WIDTH-1:0]     WID;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slv (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

`default_nettype wire

// File: rtl/axi_slv_mem.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | axi_slv_mem : AXI slave backed by a word-organised memory array  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module axi_slv_mem #(
    parameter int ID_WIDTH   = `D_ID_WIDTH,
    parameter int ADDR_WIDTH = `D_ADDR_WIDTH,
    parameter int DATA_WIDTH = `D_DATA_WIDTH,
    parameter int MEM_DEPTH  = 256
) (
    input  logic ACLK,
    input  logic ARESET,
    axi_if.slv   slv_if
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LOG2B  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;
    localparam logic [1:0] C_DECERR = 2'b11;
    localparam logic [1:0] C_INCR   = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] idx;
        idx = addr >> LOG2B;
        return idx < C_DEPTH;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> LOG2B);
    endfunction

    function automatic logic is_illegal(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'(LOG2B));
    endfunction

    // FIXED (and illegal bursts) hold the address; INCR wraps at ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        return (burst == C_INCR) ? addr + (ADDR_WIDTH'(1) << size) : addr;
    endfunction

    // ---------------- write path ----------------
    wstate_t               wstate_q, wstate_d;
    logic                  rdy_q;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            awlen_q;
    logic [2:0]            awsize_q;
    logic [1:0]            awburst_q;
    logic [7:0]            wbeat_q;
    logic                  wbad_q;
    logic                  wslverr_q;
    logic                  wdecerr_q;

    logic aw_hs, w_hs, w_last_exp, w_inr;

    assign aw_hs      = slv_if.AWVALID && rdy_q && (wstate_q == W_IDLE);
    assign w_hs       = slv_if.WVALID && (wstate_q == W_DATA);
    assign w_last_exp = (wbeat_q == awlen_q);
    assign w_inr      = in_range(waddr_q);

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && w_last_exp) wstate_d = W_RESP;
            W_RESP:  if (slv_if.BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            rdy_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rdy_q    <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awid_q    <= '0;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            wbeat_q   <= '0;
            wbad_q    <= 1'b0;
            wslverr_q <= 1'b0;
            wdecerr_q <= 1'b0;
        end else if (aw_hs) begin
            awid_q    <= slv_if.AWID;
            waddr_q   <= slv_if.AWADDR;
            awlen_q   <= slv_if.AWLEN;
            awsize_q  <= slv_if.AWSIZE;
            awburst_q <= slv_if.AWBURST;
            wbeat_q   <= '0;
            wbad_q    <= is_illegal(slv_if.AWBURST, slv_if.AWSIZE);
            wslverr_q <= is_illegal(slv_if.AWBURST, slv_if.AWSIZE);
            wdecerr_q <= 1'b0;
        end else if (w_hs) begin
            wbeat_q <= wbeat_q + 8'd1;
            waddr_q <= next_addr(waddr_q, awsize_q, awburst_q);
            if (!w_inr) begin
                wdecerr_q <= 1'b1;
            end
            if ((slv_if.WID != awid_q) || (slv_if.WLAST != w_last_exp)) begin
                wslverr_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (w_hs && w_inr && !wbad_q) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (slv_if.WSTRB[b]) begin
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= slv_if.WDATA[8*b +: 8];
                end
            end
        end
    end

    assign slv_if.AWREADY = rdy_q && (wstate_q == W_IDLE);
    assign slv_if.WREADY  = (wstate_q == W_DATA);
    assign slv_if.BVALID  = (wstate_q == W_RESP);
    assign slv_if.BID     = awid_q;
    assign slv_if.BRESP   = wdecerr_q ? C_DECERR : (wslverr_q ? C_SLVERR : C_OKAY);

    // ---------------- read path ----------------
    rstate_t               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic [1:0]            arburst_q;
    logic [7:0]            rbeat_q;
    logic                  rbad_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic                  ar_hs, r_hs;
    logic                  rload;
    logic [ADDR_WIDTH-1:0] rload_addr;
    logic                  rload_bad;
    logic                  rload_last;

    assign ar_hs = slv_if.ARVALID && rdy_q && (rstate_q == R_IDLE);
    assign r_hs  = slv_if.RREADY && (rstate_q == R_DATA);

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Selects the beat to be presented on the next cycle, if any.
    always_comb begin
        rload      = 1'b0;
        rload_addr = raddr_q;
        rload_bad  = rbad_q;
        rload_last = 1'b0;
        if (ar_hs) begin
            rload      = 1'b1;
            rload_addr = slv_if.ARADDR;
            rload_bad  = is_illegal(slv_if.ARBURST, slv_if.ARSIZE);
            rload_last = (slv_if.ARLEN == 8'd0);
        end else if (r_hs && !rlast_q) begin
            rload      = 1'b1;
            rload_addr = next_addr(raddr_q, arsize_q, arburst_q);
            rload_last = ((rbeat_q + 8'd1) == arlen_q);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arid_q    <= '0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rbeat_q   <= '0;
            rbad_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            if (ar_hs) begin
                arid_q    <= slv_if.ARID;
                arlen_q   <= slv_if.ARLEN;
                arsize_q  <= slv_if.ARSIZE;
                arburst_q <= slv_if.ARBURST;
                rbeat_q   <= '0;
            end else if (r_hs) begin
                rbeat_q <= rbeat_q + 8'd1;
            end
            if (rload) begin
                raddr_q <= rload_addr;
                rbad_q  <= rload_bad;
                rlast_q <= rload_last;
                if (rload_bad) begin
                    rdata_q <= '0;
                    rresp_q <= C_SLVERR;
                end else if (!in_range(rload_addr)) begin
                    rdata_q <= '0;
                    rresp_q <= C_DECERR;
                end else begin
                    rdata_q <= mem_q[word_idx(rload_addr)];
                    rresp_q <= C_OKAY;
                end
            end
        end
    end

    assign slv_if.ARREADY = rdy_q && (rstate_q == R_IDLE);
    assign slv_if.RVALID  = (rstate_q == R_DATA);
    assign slv_if.RID     = arid_q;
    assign slv_if.RDATA   = rdata_q;
    assign slv_if.RRESP   = rresp_q;
    assign slv_if.RLAST   = rlast_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slv_mem.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_axi_slv_mem : directed scoreboard bench for axi_slv_mem       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_axi_slv_mem;
    localparam int IDW   = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_slv_mem #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .slv_if (bus)
    );

    int tests = 0;
    int fails = 0;

    rexp_t            rq[$];
    logic [IDW+1:0]   bq[$];
    logic [DW-1:0]    model [DEPTH];
    logic [DW-1:0]    wdat [16];
    logic [3:0]       wstb [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.AWREADY;
            1:       return bus.WREADY;
            2:       return bus.BVALID;
            3:       return bus.ARREADY;
            default: return bus.RVALID;
        endcase
    endfunction

    task automatic wait_hi(input int which, input string tag);
        int n;
        n = 0;
        while (!sel(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sel(which)), 64'd1);
    endtask

    task automatic reset_chk(input string tag);
        check({tag, "_awready"}, 64'(bus.AWREADY), 0);
        check({tag, "_wready"},  64'(bus.WREADY),  0);
        check({tag, "_bvalid"},  64'(bus.BVALID),  0);
        check({tag, "_bid"},     64'(bus.BID),     0);
        check({tag, "_bresp"},   64'(bus.BRESP),   0);
        check({tag, "_arready"}, 64'(bus.ARREADY), 0);
        check({tag, "_rvalid"},  64'(bus.RVALID),  0);
        check({tag, "_rid"},     64'(bus.RID),     0);
        check({tag, "_rdata"},   64'(bus.RDATA),   0);
        check({tag, "_rresp"},   64'(bus.RRESP),   0);
        check({tag, "_rlast"},   64'(bus.RLAST),   0);
    endtask

    task automatic wr(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                      input logic [2:0] size, input logic [1:0] burst,
                      input int bad_beat, input int bhold);
        logic [AW-1:0]  a;
        logic           ill, dec, slv;
        int unsigned    wi;
        logic [IDW-1:0] bid_c;
        logic [1:0]     bresp_c;
        logic [IDW+1:0] be;
        a   = addr;
        ill = burst[1] || (size > 3'd2);
        dec = 1'b0;
        slv = ill;
        for (int i = 0; i <= len; i++) begin
            wi = a >> 2;
            if (wi >= DEPTH) dec = 1'b1;
            else if (!ill)
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) model[wi][8*b +: 8] = wdat[i][8*b +: 8];
            if (i == bad_beat) slv = 1'b1;
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        bq.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});

        @(negedge clk);
        bus.AWVALID = 1'b1; bus.AWID = id; bus.AWADDR = addr;
        bus.AWLEN = 8'(len); bus.AWSIZE = size; bus.AWBURST = burst;
        wait_hi(0, "awready");
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = wdat[i];
            bus.WSTRB  = wstb[i];
            bus.WID    = (i == bad_beat) ? ~id : id;
            bus.WLAST  = (i == len);
            wait_hi(1, "wready");
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;

        bus.BREADY = (bhold == 0);
        wait_hi(2, "bvalid");
        if (bhold > 0) begin
            bid_c   = bus.BID;
            bresp_c = bus.BRESP;
            for (int k = 0; k < bhold; k++) begin
                @(negedge clk);
                check("b_stall_valid", 64'(bus.BVALID), 1);
                check("b_stall_resp",  64'(bus.BRESP), 64'(bresp_c));
                check("b_stall_id",    64'(bus.BID),   64'(bid_c));
            end
            bus.BREADY = 1'b1;
        end
        be = bq.pop_front();
        check("bresp", 64'(bus.BRESP), 64'(be[1:0]));
        check("bid",   64'(bus.BID),   64'(be[IDW+1:2]));
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bvalid_drop", 64'(bus.BVALID), 0);
    endtask

    // mode 0: RREADY high, 1: stall first beat 5 cycles, 2: random RREADY
    task automatic rd(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                      input logic [2:0] size, input logic [1:0] burst, input int mode);
        logic [AW-1:0] a;
        logic          ill, rr, have;
        int unsigned   wi;
        int            beats, cyc, hold;
        rexp_t         e, cap;
        a   = addr;
        ill = burst[1] || (size > 3'd2);
        for (int i = 0; i <= len; i++) begin
            wi = a >> 2;
            if (ill)              e = '{data: '0,        resp: 2'b10, last: (i == len)};
            else if (wi >= DEPTH) e = '{data: '0,        resp: 2'b11, last: (i == len)};
            else                  e = '{data: model[wi], resp: 2'b00, last: (i == len)};
            rq.push_back(e);
            if (burst == 2'b01) a = a + (32'd1 << size);
        end

        @(negedge clk);
        bus.ARVALID = 1'b1; bus.ARID = id; bus.ARADDR = addr;
        bus.ARLEN = 8'(len); bus.ARSIZE = size; bus.ARBURST = burst;
        wait_hi(3, "arready");
        @(negedge clk);
        bus.ARVALID = 1'b0;

        beats = 0; cyc = 0; hold = 0; have = 1'b0; cap = '0;
        while (beats <= len && cyc < 400) begin
            if (mode == 2)                    rr = ($urandom_range(0, 1) == 1);
            else if (mode == 1 && hold < 5)   rr = 1'b0;
            else                              rr = 1'b1;
            bus.RREADY = rr;
            if (bus.RVALID) begin
                check("rid", 64'(bus.RID), 64'(id));
                if (have) begin
                    check("r_stall_data", 64'(bus.RDATA), 64'(cap.data));
                    check("r_stall_resp", 64'(bus.RRESP), 64'(cap.resp));
                    check("r_stall_last", 64'(bus.RLAST), 64'(cap.last));
                end
                if (rr) begin
                    e = rq.pop_front();
                    check("rdata", 64'(bus.RDATA), 64'(e.data));
                    check("rresp", 64'(bus.RRESP), 64'(e.resp));
                    check("rlast", 64'(bus.RLAST), 64'(e.last));
                    beats++;
                    have = 1'b0;
                end else begin
                    have = 1'b1;
                    cap  = '{data: bus.RDATA, resp: bus.RRESP, last: bus.RLAST};
                    hold++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.RREADY = 1'b0;
        check("rd_beats", 64'(beats), 64'(len + 1));
        check("rvalid_idle", 64'(bus.RVALID), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.AWVALID = 0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.WVALID = 0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 0;
        bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.RREADY = 0;
        repeat (3) @(negedge clk);
        reset_chk("rst");
        rst = 1'b0;
        #1;
        check("awready_pre_edge", 64'(bus.AWREADY), 0);
        check("arready_pre_edge", 64'(bus.ARREADY), 0);
        @(posedge clk); #1;
        check("awready_post_edge", 64'(bus.AWREADY), 1);
        check("arready_post_edge", 64'(bus.ARREADY), 1);

        // INCR 4 beats at 0x10
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        wr(4'd1, 32'h10, 3, 3'd2, 2'b01, -1, 0);
        rd(4'd1, 32'h10, 3, 3'd2, 2'b01, 0);

        // FIXED 2 beats to word 5, lane 0 only on beat 2
        wdat[0] = 32'hAAAA_AAAA; wstb[0] = 4'hF;
        wdat[1] = 32'hBBBB_BBBB; wstb[1] = 4'h1;
        wr(4'd2, 32'h14, 1, 3'd2, 2'b00, -1, 0);
        rd(4'd2, 32'h14, 0, 3'd2, 2'b01, 0);

        // crossing the end of memory
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h100 + 32'(i); wstb[i] = 4'hF; end
        wr(4'd3, 32'h3F8, 3, 3'd2, 2'b01, -1, 0);
        rd(4'd3, 32'h3F8, 3, 3'd2, 2'b01, 0);

        // WRAP burst leaves memory untouched
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hDEAD_0000 + 32'(i); wstb[i] = 4'hF; end
        wr(4'd4, 32'h10, 3, 3'd2, 2'b10, -1, 0);
        rd(4'd4, 32'h10, 3, 3'd2, 2'b01, 0);

        // WID mismatch on beat 2 (its strobes are zero)
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h4000 + 32'(i); wstb[i] = 4'hF; end
        wstb[1] = 4'h0;
        wr(4'd5, 32'h40, 3, 3'd2, 2'b01, 1, 0);
        wstb[1] = 4'hF;
        rd(4'd5, 32'h40, 3, 3'd2, 2'b01, 0);

        // oversize and reserved-burst reads
        rd(4'd6, 32'h10, 1, 3'd3, 2'b01, 0);
        rd(4'd7, 32'h10, 1, 3'd2, 2'b11, 0);

        // back-pressure on B and R
        wdat[0] = 32'h6060_6060; wstb[0] = 4'hF;
        wr(4'd8, 32'h60, 0, 3'd2, 2'b01, -1, 5);
        rd(4'd8, 32'h40, 3, 3'd2, 2'b01, 1);

        // random RREADY over an 8-beat burst
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr(4'd9, 32'h100, 7, 3'd2, 2'b01, -1, 0);
        rd(4'd9, 32'h100, 7, 3'd2, 2'b01, 2);

        // reset during W beat 2 and R beat 1
        @(negedge clk);
        bus.AWVALID = 1; bus.AWID = 4'd3; bus.AWADDR = 32'h80; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
        bus.ARVALID = 1; bus.ARID = 4'd5; bus.ARADDR = 32'h10; bus.ARLEN = 8'd3; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
        @(negedge clk);
        bus.AWVALID = 0; bus.ARVALID = 0; bus.RREADY = 0;
        check("mid_wready", 64'(bus.WREADY), 1);
        check("mid_rvalid", 64'(bus.RVALID), 1);
        bus.WVALID = 1; bus.WID = 4'd3; bus.WDATA = 32'h5A5A_0001; bus.WSTRB = 4'hF; bus.WLAST = 0;
        @(negedge clk);
        model[32] = 32'h5A5A_0001;
        bus.WDATA = 32'h5A5A_0002;
        rst = 1'b1;
        #1;
        reset_chk("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.WVALID = 0; bus.BREADY = 1; bus.RREADY = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_bvalid", 64'(bus.BVALID), 0);
            check("post_rst_rvalid", 64'(bus.RVALID), 0);
            check("post_rst_wready", 64'(bus.WREADY), 0);
        end
        bus.BREADY = 0; bus.RREADY = 0;
        wdat[0] = 32'h0C0F_FEE0; wstb[0] = 4'hF;
        wr(4'd6, 32'h84, 0, 3'd2, 2'b01, -1, 0);
        rd(4'd6, 32'h80, 1, 3'd2, 2'b01, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/axi_slv_mem.md
AXI_SLV_MEM -- requirements
Module: axi_slv_mem

Interface
REQ-001 SHALL have parameter ID_WIDTH, default `D_ID_WIDTH, width of all ID fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default `D_ADDR_WIDTH, byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default `D_DATA_WIDTH, data width; legal values 8..1024, power of two.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH-bit words of storage.
REQ-005 SHALL have ports ACLK in 1 (single clock, rising edge) and ARESET in 1 (asynchronous, active-high reset).
REQ-006 SHALL connect as AXI slave through an axi_if slv_if modport: inputs AW*/W*/AR* payload and VALID, BREADY, RREADY; outputs AWREADY, WREADY, BID[ID], BRESP[2], BVALID, ARREADY, RID[ID], RDATA[DATA_WIDTH], RRESP[2], RLAST, RVALID.

Function
REQ-007 SHALL hold storage as MEM_DEPTH words; word index = byte address >> log2(DATA_WIDTH/8); index >= MEM_DEPTH is out of range.
REQ-008 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA).
REQ-009 W_IDLE: AWREADY=1; on AWVALID&&AWREADY latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear beat counter and error flags, go to W_DATA next cycle.
REQ-010 W_DATA: AWREADY=0, WREADY=1; each WVALID&&WREADY is one beat, at most one beat per cycle.
REQ-011 Per write beat: write each byte lane with WSTRB bit set into the addressed word, unless the beat is out of range or the burst is in error; WSTRB=0 writes nothing.
REQ-012 Beat address: FIXED keeps the start address; INCR adds 2^AWSIZE per beat; carries beyond ADDR_WIDTH are discarded (wrap to 0).
REQ-013 AWBURST WRAP or reserved (2'b10, 2'b11), or AWSIZE > log2(DATA_WIDTH/8), SHALL mark the burst SLVERR, suppress all writes, and still accept AWLEN+1 beats.
REQ-014 WID != latched AWID on any beat, or WLAST mismatched to (beat == AWLEN), SHALL set SLVERR; writes of correct beats are not undone.
REQ-015 On beat number AWLEN accepted, go to W_RESP next cycle regardless of WLAST.
REQ-016 W_RESP: WREADY=0, BVALID=1, BID=latched AWID; BRESP = DECERR (2'b11) if any beat was out of range, else SLVERR (2'b10) if flagged, else OKAY (2'b00); BID/BRESP stable until BREADY; on BVALID&&BREADY go to W_IDLE.
REQ-017 R_IDLE: ARREADY=1, RVALID=0; on ARVALID&&ARREADY latch AR fields, go to R_DATA; first beat valid on the following cycle.
REQ-018 R_DATA: ARREADY=0, RVALID=1, RID=latched ARID, RLAST=1 only on beat ARLEN; RDATA/RRESP/RLAST stable while RVALID&&!RREADY.
REQ-019 On RVALID&&RREADY of a non-last beat the next beat SHALL be presented the next cycle (one beat per cycle sustained); on the last beat go to R_IDLE.
REQ-020 Read beat address follows REQ-012; out-of-range beat returns RDATA=0, RRESP=DECERR; illegal burst/size per REQ-013 returns RDATA=0, RRESP=SLVERR for all ARLEN+1 beats; else OKAY.
REQ-021 RDATA SHALL be a registered copy of memory at presentation time; a same-cycle write to that word is not reflected in that beat.
REQ-022 Write and read paths SHALL operate concurrently with no mutual stall.

Reset
REQ-023 ARESET asserted SHALL immediately force both FSMs to idle and AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RID=0, RDATA=0, RRESP=0, RLAST=0.
REQ-024 AWREADY and ARREADY SHALL rise on the first ACLK edge after ARESET deasserts.
REQ-025 Reset mid-burst SHALL abandon the burst with no response; memory contents are not reset, and beats already written remain.

Verification
REQ-026 INCR AWADDR=0x10, AWLEN=3, AWSIZE=full, WSTRB all-ones, data 1..4; then read same -> BRESP=OKAY, RDATA 1,2,3,4, RLAST only on 4th beat, RRESP=OKAY.
REQ-027 FIXED write AWLEN=1 to word 5, data 0xAA then 0xBB, WSTRB lane0 only on beat 2 -> word 5 = 0xAA with lane0 = 0xBB.
REQ-028 INCR read starting at word MEM_DEPTH-2, ARLEN=3 -> beats 1-2 OKAY with data, beats 3-4 RDATA=0, RRESP=DECERR; write equivalent -> BRESP=DECERR, in-range beats written.
REQ-029 AWBURST=WRAP, AWLEN=3 -> 4 beats accepted, memory unchanged, BRESP=SLVERR; WID mismatch on beat 2 -> BRESP=SLVERR.
REQ-030 BREADY and RREADY held low 5 cycles -> BVALID/RVALID and payloads stable throughout; RREADY toggled randomly -> no beat lost or duplicated.
REQ-031 ARESET asserted during W_DATA beat 2 and R_DATA beat 1 -> all outputs at reset values that cycle, no B/R response after release, next burst completes OKAY.
